// File: rtl/ss_pkg.sv
// Shared types and constants for the stochastic-to-binary deconverter.
package ss_pkg;

    localparam int SS_WINDOW_LOG2 = 8;
    localparam int SS_RESULT_MAX  = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        ACCUM  = 2'd2,
        DONE   = 2'd3
    } ss_state_e;

    // A full window of ones counts 256, one past what 8 bits can hold.
    function automatic logic [SS_WINDOW_LOG2-1:0] ss_saturate(
        input logic [SS_WINDOW_LOG2:0] cnt
    );
        if (cnt > (SS_WINDOW_LOG2+1)'(SS_RESULT_MAX))
            return SS_WINDOW_LOG2'(SS_RESULT_MAX);
        return cnt[SS_WINDOW_LOG2-1:0];
    endfunction

endpackage

// File: rtl/ss_ones_counter.sv
// Ones-count and sample counter for one accumulation window.
module ss_ones_counter
    import ss_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic                    z_i,
    output logic [SS_WINDOW_LOG2:0] ones_o,
    output logic                    wrap_o
);

    logic [SS_WINDOW_LOG2-1:0] samp_q, samp_d;
    logic [SS_WINDOW_LOG2:0]   ones_q, ones_d;

    always_comb begin
        samp_d = samp_q;
        ones_d = ones_q;
        if (clr_i) begin
            samp_d = '0;
            ones_d = '0;
        end else if (en_i) begin
            samp_d = samp_q + SS_WINDOW_LOG2'(1);
            ones_d = ones_q + {{SS_WINDOW_LOG2{1'b0}}, z_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_q <= '0;
            ones_q <= '0;
        end else begin
            samp_q <= samp_d;
            ones_q <= ones_d;
        end
    end

    // The 255->0 wrap marks the last sample of the window.
    assign wrap_o = en_i && !clr_i && (samp_q == '1);
    assign ones_o = ones_q;

endmodule

// File: rtl/ss_deconverter_8bit.sv
// Converts a 256-cycle stochastic bitstream window to an 8-bit estimate.
// Optional warm-up phase: define SS_DECONV_WARMUP_EN.
module ss_deconverter_8bit
    import ss_pkg::*;
#(
    parameter int WARMUP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       clear,
    input  logic       z_ss,
    output logic       busy,
    output logic [7:0] result,
    output logic       valid
);

    if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255) begin : g_cfg_chk
        $error("WARMUP_CYCLES must be in 1..255");
    end

    ss_state_e state_q, state_d;
    logic [7:0] result_q, result_d;
    logic       valid_q, valid_d;
    logic [SS_WINDOW_LOG2:0] ones;
    logic       wrap;
    logic       cnt_clr;
    logic       warm_done;

`ifdef SS_DECONV_WARMUP_EN
    localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);
    logic [7:0] wcnt_q, wcnt_d;

    assign wcnt_d    = (state_q == WARMUP && !clear) ? wcnt_q + 8'd1 : 8'd0;
    assign warm_done = (wcnt_q == WARM_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wcnt_q <= 8'd0;
        else      wcnt_q <= wcnt_d;
    end
`else
    assign warm_done = 1'b0;
`endif

    // Counters stay zeroed until ACCUM and hold through DONE for the load.
    assign cnt_clr = clear || state_q == IDLE || state_q == WARMUP;

    ss_ones_counter u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (state_q == ACCUM),
        .z_i    (z_ss),
        .ones_o (ones),
        .wrap_o (wrap)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef SS_DECONV_WARMUP_EN
                    state_d = WARMUP;
`else
                    state_d = ACCUM;
`endif
                end
            end
            WARMUP: if (warm_done) state_d = ACCUM;
            ACCUM:  if (wrap) state_d = DONE;
            DONE: begin
                state_d  = IDLE;
                result_d = ss_saturate(ones);
                valid_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d  = IDLE;
            result_d = result_q;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            result_q <= 8'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign result = result_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_ss_deconverter_8bit.sv
// Randomized self-checking bench for ss_deconverter_8bit.
module tb_ss_deconverter_8bit;

    localparam int WC = 16;
`ifdef SS_DECONV_WARMUP_EN
    localparam int W = WC;
`else
    localparam int W = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic       z_ss = 1'b0;
    logic       busy;
    logic       valid;
    logic [7:0] result;

    int n_cmp = 0;
    int n_bad = 0;
    int last_res = 0;

    always #5 clk = ~clk;

    ss_deconverter_8bit #(.WARMUP_CYCLES(WC)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .clear  (clear),
        .z_ss   (z_ss),
        .busy   (busy),
        .result (result),
        .valid  (valid)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Bit fed before the c-th edge after the start edge; s is the window index.
    function automatic logic zval(input int mode, input int c, input int pct);
        int s;
        s = c - W - 1;
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (s >= 0) && (s % 2 == 0);
            4:       return (c <= 16);
            default: return ($urandom_range(0, 99) < pct);
        endcase
    endfunction

    // One conversion: expected result is the saturated popcount of the
    // 256 bits that fall inside the window following any warm-up.
    task automatic convert(input string tag, input int mode, input int pct,
                           input int inj, input int clr_at);
        int  sum;
        int  exp;
        logic zb;
        sum = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/busy_start"}, busy, 1);
        for (int c = 1; c <= W + 260; c++) begin
            zb    = zval(mode, c, pct);
            z_ss  = zb;
            start = (c == inj);
            clear = (c == clr_at);
            if (c >= W + 1 && c <= W + 256) sum += int'(zb);
            @(negedge clk);
            start = 1'b0;
            clear = 1'b0;
            if (clr_at > 0 && c >= clr_at) begin
                chk({tag, "/clr_busy"}, busy, 0);
                chk({tag, "/clr_valid"}, valid, 0);
                chk({tag, "/clr_result"}, result, last_res);
                if (c >= clr_at + 3) break;
            end else begin
                chk({tag, "/valid"}, valid, int'(c == W + 257));
                if (c == W + 256) begin
                    chk({tag, "/busy_done"}, busy, 1);
                    chk({tag, "/hold"}, result, last_res);
                end
                if (c == W + 257) begin
                    exp = (sum > 255) ? 255 : sum;
                    chk({tag, "/result"}, result, exp);
                    chk({tag, "/busy_idle"}, busy, 0);
                    last_res = exp;
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst/busy", busy, 0);
        chk("rst/valid", valid, 0);
        chk("rst/result", result, 0);
        rst = 1'b1;

        repeat (4) @(negedge clk);
        chk("idle/busy", busy, 0);

        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        chk("clr_prio/busy", busy, 0);

        convert("ones", 0, 0, 0, 0);
        convert("zeros", 1, 0, 0, 0);
        convert("alt", 2, 0, 0, 0);
        convert("rnd30", 3, 30, 0, 0);
        convert("rnd_inj", 3, 60, W + 100, 0);
        convert("rnd85", 3, 85, 0, 0);
        convert("rnd_pre_clr", 3, 20, 0, 0);
        convert("clr50", 0, 0, 0, W + 50);
        convert("after_clr", 0, 0, 0, 0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        z_ss  = 1'b1;
        repeat (W + 200) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst/busy", busy, 0);
        chk("arst/valid", valid, 0);
        chk("arst/result", result, 0);
        last_res = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (valid) begin
                chk("arst/stray_valid", valid, 0);
                break;
            end
        end
        chk("arst/idle", busy, 0);
        convert("post_rst", 0, 0, 0, 0);

        convert("warm_stream", 4, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ss_deconverter_8bit.md
SS_DECONVERTER_8BIT -- requirements
Module: ss_deconverter_8bit

Interface
REQ-001 SHALL provide parameter WARMUP_CYCLES, default 16: cycles discarded before accumulation when warm-up is compiled in (range 1..255).
REQ-002 SHALL provide port clk, input, 1, clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL provide port start, input, 1, request one conversion; sampled only in IDLE.
REQ-005 SHALL provide port clear, input, 1, synchronous abort to IDLE.
REQ-006 SHALL provide port z_ss, input, 1, stochastic bitstream from the divider's z_output.
REQ-007 SHALL provide port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL provide port result, output, 8, last completed binary estimate.
REQ-009 SHALL provide port valid, output, 1, one-cycle pulse when result updates.

Function
REQ-010 SHALL implement FSM states IDLE, WARMUP, ACCUM and DONE.
REQ-011 IDLE with start=1 SHALL go to WARMUP when the warm-up macro is defined, else to ACCUM; start=0 SHALL stay in IDLE.
REQ-012 WARMUP SHALL last exactly WARMUP_CYCLES cycles, ignore z_ss, then enter ACCUM.
REQ-013 On entering ACCUM, the 9-bit ones-count and the 8-bit sample counter SHALL both be zero.
REQ-014 ACCUM SHALL last exactly 256 cycles, adding z_ss to the ones-count on every cycle.
REQ-015 After the 256th sample, the FSM SHALL enter DONE, load result = min(ones-count, 255) and assert valid for that single cycle.
REQ-016 The sample counter SHALL wrap 255->0 on the last sample; that wrap SHALL be the ACCUM->DONE condition.
REQ-017 DONE SHALL return to IDLE unconditionally on the next edge; start seen during DONE SHALL be ignored.
REQ-018 Latency without warm-up: start sampled at edge k -> valid high after edge k+257; with warm-up, add WARMUP_CYCLES.
REQ-019 start asserted while busy=1 SHALL be ignored, with no effect on counters.
REQ-020 clear=1 SHALL force IDLE on the next edge from any state, zero both counters and leave result unchanged; no valid pulse.
REQ-021 clear and start high together SHALL give clear priority.
REQ-022 result SHALL hold its value between valid pulses.

Reset
REQ-023 rst=0 SHALL asynchronously force state IDLE, both counters 0, the warm-up counter 0, result=8'd0, valid=0 and busy=0.
REQ-024 Reset mid-conversion SHALL discard the partial count; after release, no valid pulse until a new start completes.

Configuration
REQ-025 Macro SS_DECONV_WARMUP_EN defined: the WARMUP state and its 8-bit counter SHALL exist and be used per REQ-011/012.
REQ-026 Macro SS_DECONV_WARMUP_EN undefined: the WARMUP state and its counter SHALL be absent, IDLE SHALL go directly to ACCUM, and WARMUP_CYCLES SHALL be unused.

Structure
REQ-027 Shared package ss_pkg SHALL hold the state typedef (IDLE/WARMUP/ACCUM/DONE), SS_WINDOW_LOG2=8 and SS_RESULT_MAX=255.
REQ-028 Sub-module ss_ones_counter SHALL hold the 9-bit ones-count and sample counter, with clear, enable and wrap outputs; the FSM SHALL stay in the top module.

Verification
REQ-029 No macro, z_ss constant 1, single start pulse -> valid after 257 cycles, result=255 (saturation of count 256).
REQ-030 z_ss constant 0 -> result=0; z_ss alternating 1,0 starting with 1 in the first ACCUM cycle -> result=128.
REQ-031 start pulsed again at cycle 100 of ACCUM -> ignored; exactly one valid, at the original time, with the correct count.
REQ-032 clear at ACCUM cycle 50 (z_ss=1) -> IDLE, busy=0, no valid, result keeps its prior value; a later start gives the full 256-sample result.
REQ-033 rst=0 at ACCUM cycle 200 -> immediate IDLE, result=0, valid=0; after release and a new start with z_ss=1 -> result=255.
REQ-034 SS_DECONV_WARMUP_EN defined, WARMUP_CYCLES=16, z_ss=1 for the 16 warm-up cycles then 0 -> result=0 and valid at 273 cycles; same stream without the macro -> result=16.
